// File: rtl/event_stream_packer.sv
// Buffers filtered events in a small FIFO, extends timestamps with a 4-bit epoch and streams
// 8-bit words over valid/ready, inserting an epoch marker on timestamp wrap.
// Optional: define EVT_PACKER_DROP_CNT_EN to implement the saturating drop counter.
module event_stream_packer #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        x_in,
  input  logic [1:0]        y_in,
  input  logic [1:0]        p_in,
  input  logic [1:0]        t_in,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              fifo_full,
  output logic [DROP_W-1:0] drop_count
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, MARK, EVT} state_e;

  typedef struct packed {
    logic       mark;
    logic [3:0] epoch;
    logic [7:0] evt;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          fifo_full_q;
  logic [1:0]    last_t_q;
  logic [3:0]    epoch_q, epoch_d;
  logic          pending_q, pending_d;
  state_e        state_q, state_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    evt_q, evt_d;

  logic   in_vld, wrap, mark, push, pop, drop, fifo_empty;
  entry_t new_entry, head;

  assign in_vld     = (p_in == 2'b01);
  // Dropped events still advance the epoch so later timestamps stay consistent.
  assign wrap       = in_vld && (t_in < last_t_q);
  assign epoch_d    = epoch_q + 4'(wrap);
  assign mark       = wrap | pending_q;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign new_entry  = '{mark: mark, epoch: epoch_d, evt: {x_in, y_in, p_in, t_in}};
  assign push       = in_vld && ((count_q < FULL_CNT) || pop);
  assign drop       = in_vld && !push;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    if (push)              pending_d = 1'b0;
    else if (drop && mark) pending_d = 1'b1;
  end

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    evt_d       = evt_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: pop = !fifo_empty;
      MARK: begin
        if (out_ready) begin
          out_data_d = evt_q;
          state_d    = EVT;
        end
      end
      EVT: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      evt_d       = head.evt;
      out_valid_d = 1'b1;
      if (head.mark) begin
        state_d    = MARK;
        out_data_d = {head.epoch, 2'b10, 2'b00};
      end else begin
        state_d    = EVT;
        out_data_d = head.evt;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      last_t_q    <= 2'b00;
      epoch_q     <= 4'h0;
      pending_q   <= 1'b0;
      state_q     <= IDLE;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      evt_q       <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      fifo_full_q <= (count_d == FULL_CNT);
      if (in_vld) begin
        last_t_q <= t_in;
        epoch_q  <= epoch_d;
      end
      pending_q   <= pending_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      evt_q       <= evt_d;
    end
  end

  // NOTE: storage is not reset; the count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

`ifdef EVT_PACKER_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                           drop_cnt_q <= '0;
    else if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign fifo_full = fifo_full_q;

endmodule

// File: tb/tb_event_stream_packer.sv
// Scoreboard bench for event_stream_packer: a spec-level epoch/marker model queues expected
// words as events are driven; a monitor compares them as the DUT presents output.
module tb_event_stream_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] x_in, y_in, p_in, t_in;
  logic [7:0] out_data;
  logic       out_valid, out_ready, fifo_full;
  logic [7:0] drop_count;

  int errs   = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [1:0] m_last_t;
  logic [3:0] m_epoch;
  logic       m_pend;

  event_stream_packer #(.DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in(x_in), .y_in(y_in), .p_in(p_in), .t_in(t_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_drop(input int n);
`ifdef EVT_PACKER_DROP_CNT_EN
    return 8'(n);
`else
    return 8'(n - n);
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_last_t = 2'b00;
    m_epoch  = 4'h0;
    m_pend   = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p_in  = 2'b00;
    model_reset();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Drives one valid event for one cycle; accept says whether the FIFO has room for it.
  task automatic send(input logic [1:0] x, input logic [1:0] y, input logic [1:0] t, input bit accept);
    logic wrap, mark;
    x_in = x; y_in = y; t_in = t; p_in = 2'b01;
    wrap = (t < m_last_t);
    if (wrap) m_epoch = m_epoch + 4'd1;
    m_last_t = t;
    mark = wrap | m_pend;
    if (accept) begin
      if (mark) exp_q.push_back({m_epoch, 4'b1000});
      exp_q.push_back({x, y, 2'b01, t});
      m_pend = 1'b0;
    end else if (mark) begin
      m_pend = 1'b1;
    end
    tick(1);
    p_in = 2'b00;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", out_valid, 1'b0);
    tick(1);
  endtask

  // Monitor: the presented word must be the scoreboard head; it retires on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", out_valid, 1'b0);
      end else begin
        check("word", out_data, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    x_in = 2'b00; y_in = 2'b00; t_in = 2'b00; p_in = 2'b00;
    out_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_full", fifo_full, 1'b0);
    check("rst_drop", drop_count, 8'h00);

    // Single event: two-cycle latency, one-cycle valid, no marker.
    tick(1);
    out_ready = 1'b1;
    send(2'd1, 2'd2, 2'd1, 1'b1);
    @(negedge clk);
    check("lat_n1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_n2_valid", out_valid, 1'b1);
    check("lat_n2_data", out_data, 8'h65);
    @(negedge clk);
    check("lat_n3_valid", out_valid, 1'b0);
    tick(1);

    // Wrap: F7, marker 18, 04.
    send(2'd3, 2'd3, 2'd3, 1'b1);
    send(2'd0, 2'd0, 2'd0, 1'b1);
    check("wrap_seq_len", exp_q.size(), 3);
    wait_drain();

    // Backpressure: first event on output, four fill the FIFO, sixth is dropped.
    out_ready = 1'b0;
    send(2'd1, 2'd0, 2'd0, 1'b1);
    send(2'd2, 2'd1, 2'd1, 1'b1);
    send(2'd3, 2'd2, 2'd1, 1'b1);
    send(2'd0, 2'd3, 2'd2, 1'b1);
    send(2'd1, 2'd1, 2'd3, 1'b1);
    @(negedge clk);
    check("bp_full", fifo_full, 1'b1);
    check("bp_drop0", drop_count, 8'h00);
    tick(1);
    send(2'd2, 2'd2, 2'd3, 1'b0);
    @(negedge clk);
    check("bp_drop1", drop_count, exp_drop(1));
    check("bp_full_hold", fifo_full, 1'b1);
    tick(1);
    out_ready = 1'b1;
    wait_drain();
    check("bp_full_clr", fifo_full, 1'b0);

    // Dropped event carries the wrap; marker rides on the next accepted event.
    do_reset();
    out_ready = 1'b0;
    send(2'd0, 2'd1, 2'd0, 1'b1);
    send(2'd1, 2'd1, 2'd1, 1'b1);
    send(2'd2, 2'd1, 2'd2, 1'b1);
    send(2'd3, 2'd1, 2'd2, 1'b1);
    send(2'd0, 2'd2, 2'd2, 1'b1);
    send(2'd1, 2'd2, 2'd1, 1'b0);
    @(negedge clk);
    check("carry_drop", drop_count, exp_drop(1));
    tick(1);
    out_ready = 1'b1;
    send(2'd2, 2'd3, 2'd1, 1'b1);
    check("carry_marker", exp_q[exp_q.size()-2], 8'h18);
    wait_drain();

    // Reset mid-transfer abandons the held word.
    out_ready = 1'b0;
    send(2'd3, 2'd0, 2'd3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("mid_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_drop", drop_count, 8'h00);
    check("mid_rst_full", fifo_full, 1'b0);
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'd1, 2'd1, 2'd2, 1'b1);
    send(2'd1, 2'd1, 2'd1, 1'b1);
    check("mid_epoch_marker", exp_q[exp_q.size()-2], 8'h18);
    wait_drain();

    // Sixteen wraps: marker epoch runs 1..15 then 0.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(2'(i), 2'(i >> 2), 2'd3, 1'b1);
      send(2'(i + 1), 2'd2, 2'd0, 1'b1);
      tick(2);
    end
    wait_drain();

    // Full FIFO with simultaneous push and pop, then ignored p values.
    out_ready = 1'b0;
    send(2'd0, 2'd0, 2'd0, 1'b1);
    send(2'd1, 2'd0, 2'd1, 1'b1);
    send(2'd2, 2'd0, 2'd1, 1'b1);
    send(2'd3, 2'd0, 2'd2, 1'b1);
    send(2'd0, 2'd1, 2'd3, 1'b1);
    @(negedge clk);
    check("pp_full_before", fifo_full, 1'b1);
    tick(1);
    out_ready = 1'b1;
    send(2'd1, 2'd1, 2'd3, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    check("pp_full_after", fifo_full, 1'b1);
    check("pp_no_drop", drop_count, 8'h00);
    tick(1);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      x_in = 2'($urandom_range(0, 3));
      y_in = 2'($urandom_range(0, 3));
      t_in = 2'($urandom_range(0, 3));
      p_in = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b10 : 2'b11);
      tick(1);
    end
    p_in = 2'b00;
    wait_drain();
    tick(3);
    @(negedge clk);
    check("ignored_valid", out_valid, 1'b0);
    check("ignored_full", fifo_full, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
